// File: rtl/servo_pwm_decoder_pkg.sv
// Shared constants, FSM encoding and the width clamp for the servo PWM decoder.
// Parameter defaults assume a 50 MHz clock and a 1 us measurement tick.
package servo_pwm_decoder_pkg;

  localparam int CLK_DIV_DEF = 50;
  localparam int W_MIN_DEF   = 450;
  localparam int W_MAX_DEF   = 2550;
  localparam int P_MIN_DEF   = 15000;
  localparam int P_MAX_DEF   = 25000;
  localparam int TIMEOUT_DEF = 30000;

  localparam int OFFSET_US  = 500;
  localparam int SPAN_US    = 2000;
  localparam int FULL_SCALE = 1023;
  localparam int DIV_STEPS  = 21;

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

  // Map a raw width onto 0..SPAN_US, saturating outside the nominal servo range.
  function automatic logic [10:0] clamp_width(input logic [15:0] w);
    if (w < 16'(OFFSET_US)) return 11'd0;
    if (w > 16'(OFFSET_US + SPAN_US)) return 11'(SPAN_US);
    return 11'(w - 16'(OFFSET_US));
  endfunction

endpackage

// File: rtl/servo_pwm_decoder_if.sv
// Signal bundle between the decoder (master) and whoever feeds and reads it (slave).
// Handshake: valid and err are single-cycle strobes with no back-pressure; position,
// width_us and period_us are stable from the valid strobe until the next one.
interface servo_pwm_decoder_if;
  import servo_pwm_decoder_pkg::*;

  logic        pwm_in;
  logic [9:0]  position;
  logic [15:0] width_us;
  logic [15:0] period_us;
  logic        valid;
  logic        err;
  logic        locked;
  state_t      state;

  modport master (
    input  pwm_in,
    output position, width_us, period_us, valid, err, locked, state
  );

  modport slave (
    output pwm_in,
    input  position, width_us, period_us, valid, err, locked, state
  );
endinterface

// File: rtl/servo_pwm_decoder_seq_divider.sv
// 21-bit by 11-bit restoring divider; the first step runs in the start cycle,
// so done strobes exactly DIV_STEPS cycles after start.
module servo_pwm_decoder_seq_divider
  import servo_pwm_decoder_pkg::*;
#(
  parameter int QW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [20:0]   dividend,
  input  logic [10:0]   divisor,
  output logic          busy,
  output logic          done,
  output logic [QW-1:0] quotient
);

  logic [10:0] rem, rem_src, rem_nxt;
  logic [20:0] quo, quo_src, quo_nxt;
  logic [11:0] shifted;
  logic [4:0]  steps;

  always_comb begin
    rem_src = start ? 11'd0 : rem;
    quo_src = start ? dividend : quo;
    shifted = {rem_src, quo_src[20]};
    rem_nxt = shifted[10:0];
    quo_nxt = {quo_src[19:0], 1'b0};
    if (shifted >= {1'b0, divisor}) begin
      rem_nxt    = 11'(shifted - {1'b0, divisor});
      quo_nxt[0] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem   <= '0;
      quo   <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        steps <= 5'(DIV_STEPS - 1);
        busy  <= 1'b1;
      end else if (busy) begin
        rem   <= rem_nxt;
        quo   <= quo_nxt;
        steps <= steps - 5'd1;
        if (steps == 5'd1) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo[QW-1:0];

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures servo pulse width and period on a tick grid, validates each frame and
// converts accepted widths back to a 10-bit position.
module servo_pwm_decoder
  import servo_pwm_decoder_pkg::*;
#(
  parameter int CLK_DIV = CLK_DIV_DEF,
  parameter int W_MIN   = W_MIN_DEF,
  parameter int W_MAX   = W_MAX_DEF,
  parameter int P_MIN   = P_MIN_DEF,
  parameter int P_MAX   = P_MAX_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic                 clk,
  input logic                 rst,
  servo_pwm_decoder_if.master bus
);

  localparam int PW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [1:0]    sync_q;
  logic          sync_d, rise, fall;
  logic [PW-1:0] pre_cnt;
  logic          tick;
  logic [15:0]   cnt, w_cap, pend_w, pend_p;
  state_t        state;
  logic          div_start, div_busy, div_done;
  logic [20:0]   dividend;
  logic [9:0]    quotient;
  logic [9:0]    position_q;
  logic [15:0]   width_q, period_q;
  logic          valid_q, err_q, locked_q, good_seen;
  logic          timeout, frame_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      sync_d <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], bus.pwm_in};
      sync_d <= sync_q[1];
      rise   <= sync_q[1] & ~sync_d;
      fall   <= ~sync_q[1] & sync_d;
    end
  end

  assign tick = (pre_cnt == PW'(CLK_DIV - 1));

  // Free-running prescaler; a rise clears the frame counter even on a tick cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      if (rise) cnt <= '0;
      else if (tick && cnt != 16'hFFFF) cnt <= cnt + 16'd1;
    end
  end

  assign timeout  = (cnt >= 16'(TIMEOUT));
  assign frame_ok = (w_cap >= 16'(W_MIN)) && (w_cap <= 16'(W_MAX)) &&
                    (cnt >= 16'(P_MIN)) && (cnt <= 16'(P_MAX)) &&
                    !div_busy && !div_start;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_SYNC;
      w_cap      <= '0;
      pend_w     <= '0;
      pend_p     <= '0;
      dividend   <= '0;
      div_start  <= 1'b0;
      position_q <= '0;
      width_q    <= '0;
      period_q   <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      locked_q   <= 1'b0;
      good_seen  <= 1'b0;
    end else begin
      div_start <= 1'b0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      case (state)
        ST_SYNC: if (rise) state <= ST_HIGH;
        ST_HIGH: begin
          if (fall) begin
            w_cap <= cnt;
            state <= ST_LOW;
          end else if (timeout) begin
            state     <= ST_SYNC;
            locked_q  <= 1'b0;
            good_seen <= 1'b0;
          end
        end
        ST_LOW: begin
          if (rise) begin
            state <= ST_HIGH;
            if (frame_ok) begin
              div_start <= 1'b1;
              dividend  <= 21'(clamp_width(w_cap)) * 21'(FULL_SCALE);
              pend_w    <= w_cap;
              pend_p    <= cnt;
            end else begin
              err_q     <= 1'b1;
              locked_q  <= 1'b0;
              good_seen <= 1'b0;
            end
          end else if (timeout) begin
            state     <= ST_SYNC;
            locked_q  <= 1'b0;
            good_seen <= 1'b0;
          end
        end
        default: state <= ST_SYNC;
      endcase
      // A finished divide publishes the frame; the second good one in a row locks.
      if (div_done) begin
        position_q <= quotient;
        width_q    <= pend_w;
        period_q   <= pend_p;
        valid_q    <= 1'b1;
        good_seen  <= 1'b1;
        if (good_seen) locked_q <= 1'b1;
      end
    end
  end

  servo_pwm_decoder_seq_divider #(.QW(10)) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .dividend (dividend),
    .divisor  (11'(SPAN_US)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  assign bus.position  = position_q;
  assign bus.width_us  = width_q;
  assign bus.period_us = period_q;
  assign bus.valid     = valid_q;
  assign bus.err       = err_q;
  assign bus.locked    = locked_q;
  assign bus.state     = state;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Bench for servo_pwm_decoder with a 1-clk tick so frames stay short; widths and
// periods below are in ticks, and each tick in a frame is one clk after the rise.
module tb_servo_pwm_decoder;
  import servo_pwm_decoder_pkg::*;

  localparam int TB_CLK_DIV = 1;
  localparam int TB_P_MIN   = 2650;
  localparam int TB_P_MAX   = 3000;
  localparam int TB_TIMEOUT = 3200;
  localparam int LAT        = 26;
  localparam int ERR_LAT    = 4;

  logic clk, rst;
  servo_pwm_decoder_if bus ();

  servo_pwm_decoder #(
    .CLK_DIV (TB_CLK_DIV),
    .W_MIN   (450),
    .W_MAX   (2550),
    .P_MIN   (TB_P_MIN),
    .P_MAX   (TB_P_MAX),
    .TIMEOUT (TB_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  // clock / cycle count
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pcyc = 0;
  always @(posedge clk) pcyc++;

  int vectors = 0;
  int miscompares = 0;

  // reference model state
  logic [41:0] exp_q[$];
  bit  have_prev = 0;
  int  prev_w = 0, prev_p = 0, run = 0;
  int  m_pos = 0, m_w = 0, m_p = 0, exp_valid = 0, exp_err = 0;
  bit  m_locked = 0;
  int  valid_cnt = 0, err_cnt = 0, last_valid_cyc = -1, last_err_cyc = -1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic bit frame_good(input int w, input int p);
    return (w >= 450) && (w <= 2550) && (p >= TB_P_MIN) && (p <= TB_P_MAX);
  endfunction

  function automatic int exp_position(input int w);
    int c;
    c = (w < 500) ? 0 : (w > 2500) ? 2000 : (w - 500);
    return (c * 1023) / 2000;
  endfunction

  // scoreboard
  always @(negedge clk) begin
    if (bus.valid) begin
      valid_cnt++;
      last_valid_cyc = pcyc;
      check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0)
        check("sb_frame", 64'({bus.position, bus.width_us, bus.period_us}), 64'(exp_q.pop_front()));
    end
    if (bus.err) begin
      err_cnt++;
      last_err_cyc = pcyc;
    end
  end

  // driver: one frame of w ticks high, p ticks period; its rise closes the previous frame
  task automatic send_frame(input int w, input int p);
    int  rise_cyc;
    bit  evald, good;
    bus.pwm_in = 1'b1;
    rise_cyc = pcyc;
    evald = have_prev;
    good  = evald && frame_good(prev_w, prev_p);
    if (good) begin
      exp_q.push_back({10'(exp_position(prev_w)), 16'(prev_w), 16'(prev_p)});
      exp_valid++;
      run++;
      m_pos = exp_position(prev_w);
      m_w   = prev_w;
      m_p   = prev_p;
      if (run >= 2) m_locked = 1;
    end else if (evald) begin
      exp_err++;
      run = 0;
      m_locked = 0;
    end
    repeat (27) @(negedge clk);
    check("valid_count", 64'(valid_cnt), 64'(exp_valid));
    check("err_count", 64'(err_cnt), 64'(exp_err));
    if (good) check("valid_latency", 64'(last_valid_cyc), 64'(rise_cyc + LAT));
    if (evald && !good) check("err_latency", 64'(last_err_cyc), 64'(rise_cyc + ERR_LAT));
    check("position", 64'(bus.position), 64'(m_pos));
    check("width_us", 64'(bus.width_us), 64'(m_w));
    check("period_us", 64'(bus.period_us), 64'(m_p));
    check("locked", 64'(bus.locked), 64'(m_locked));
    repeat (w + 1 - 27) @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (p - w) @(negedge clk);
    if (p > TB_TIMEOUT) begin
      have_prev = 0;
      run = 0;
      m_locked = 0;
      check("timeout_state", 64'(bus.state), 64'(ST_SYNC));
      check("timeout_locked", 64'(bus.locked), 64'(m_locked));
      check("timeout_no_err", 64'(err_cnt), 64'(exp_err));
    end else begin
      have_prev = 1;
      prev_w = w;
      prev_p = p;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_position"}, 64'(bus.position), 64'd0);
    check({tag, "_width"}, 64'(bus.width_us), 64'd0);
    check({tag, "_period"}, 64'(bus.period_us), 64'd0);
    check({tag, "_valid"}, 64'(bus.valid), 64'd0);
    check({tag, "_err"}, 64'(bus.err), 64'd0);
    check({tag, "_locked"}, 64'(bus.locked), 64'd0);
    check({tag, "_state"}, 64'(bus.state), 64'(ST_SYNC));
  endtask

  initial begin
    int w, p;
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // nominal 1500-tick pulses, lock after the second valid
    repeat (3) send_frame(1500, 2700);
    // clamp boundaries, raw width reported
    send_frame(500, 2700);
    send_frame(2500, 2700);
    send_frame(470, 2700);
    send_frame(2540, 2700);
    // out-of-range widths
    send_frame(400, 2700);
    send_frame(2600, 2700);
    // short period rejected, relock after two good frames
    send_frame(1500, 2200);
    send_frame(1500, 2700);
    send_frame(1500, 2700);
    send_frame(1500, 2700);
    // loss of signal: held low, then held high
    send_frame(1500, 3300);
    send_frame(3300, 3350);
    send_frame(1000, 2700);
    send_frame(2000, 2700);
    send_frame(1500, 2700);

    // reset in the middle of a divide
    bus.pwm_in = 1'b1;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    bus.pwm_in = 1'b0;
    @(negedge clk);
    check_idle_outputs("mid_div_reset");
    repeat (40) @(negedge clk);
    check("reset_no_valid", 64'(valid_cnt), 64'(exp_valid));
    rst = 1'b0;
    have_prev = 0;
    run = 0;
    m_pos = 0; m_w = 0; m_p = 0;
    m_locked = 0;
    repeat (5) @(negedge clk);
    send_frame(1500, 2700);

    // randomized widths and periods around the acceptance windows
    for (int i = 0; i < 3; i++) begin
      w = $urandom_range(400, 2600);
      p = $urandom_range(2620, 2800);
      send_frame(w, p);
    end
    send_frame(1500, 2700);
    send_frame(1500, 2700);

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
